// File: rtl/pipelined_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_chunk_adder
// Brief    : WIDTH-bit add/subtract built from CHUNK-bit ripple slices, one
//            register stage per slice, valid/ready handshake with a global
//            stall. Upper operand slices travel down the pipe and finished low
//            result slices travel with them so a whole result exits at once.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             ovf
);

  localparam int c_STAGES = WIDTH / CHUNK;

  if ((WIDTH % CHUNK) != 0 || c_STAGES < 1 || c_STAGES > 32) begin : g_bad_params
    $error("pipelined_chunk_adder: WIDTH must be a multiple of CHUNK with 1..32 stages");
  end

  // Whole pipe advances together whenever the output slot is free or drained.
  // in_ready is therefore combinational on out_ready.
  logic w_en;
  assign w_en     = ~out_valid | out_ready;
  assign in_ready = w_en;

  for (genvar k = 0; k < c_STAGES; k++) begin : g_stage
    // Operand bits still unresolved when they reach this stage.
    localparam int c_IN_W = WIDTH - k * CHUNK;

    logic [c_IN_W-1:0]      w_opa;
    logic [c_IN_W-1:0]      w_opb;
    logic                   w_cin;
    logic                   w_vin;
    logic [CHUNK-1:0]       w_slice;
    logic                   w_cout;
    logic [(k+1)*CHUNK-1:0] w_sum_nxt;

    logic                   r_valid;
    logic                   r_carry;
    logic [(k+1)*CHUNK-1:0] r_sum;

    if (k == 0) begin : g_head
      // Subtraction enters as A + ~B + 1; the +1 is the slice-0 carry-in.
      assign w_opa     = a;
      assign w_opb     = b ^ {WIDTH{sub}};
      assign w_cin     = sub;
      assign w_vin     = in_valid;
      assign w_sum_nxt = w_slice;
    end else begin : g_body
      assign w_opa     = g_stage[k-1].g_fwd.r_a;
      assign w_opb     = g_stage[k-1].g_fwd.r_b;
      assign w_cin     = g_stage[k-1].r_carry;
      assign w_vin     = g_stage[k-1].r_valid;
      assign w_sum_nxt = {w_slice, g_stage[k-1].r_sum};
    end

    // Plain ripple of full-adder cells across this stage's slice.
    always_comb begin
      logic w_rip;
      w_rip   = w_cin;
      w_slice = '0;
      for (int i = 0; i < CHUNK; i++) begin
        w_slice[i] = w_opa[i] ^ w_opb[i] ^ w_rip;
        w_rip      = (w_opa[i] & w_opb[i]) | (w_rip & (w_opa[i] ^ w_opb[i]));
      end
      w_cout = w_rip;
    end

    // Stage register: valid bit, accumulated low result and slice carry-out.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_carry <= 1'b0;
        r_sum   <= '0;
      end else if (w_en) begin
        r_valid <= w_vin;
        r_carry <= w_cout;
        r_sum   <= w_sum_nxt;
      end
    end

    if (k == c_STAGES - 1) begin : g_last
      // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
      logic w_cmsb;
      logic r_ovf;
      assign w_cmsb = w_opa[CHUNK-1] ^ w_opb[CHUNK-1] ^ w_slice[CHUNK-1];

      // Signed overflow registered alongside the final result slice.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_en) begin
          r_ovf <= w_cmsb ^ w_cout;
        end
      end
    end else begin : g_fwd
      logic [c_IN_W-CHUNK-1:0] r_a;
      logic [c_IN_W-CHUNK-1:0] r_b;

      // Delay-match the operand slices not yet consumed.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_opa[c_IN_W-1:CHUNK];
          r_b <= w_opb[c_IN_W-1:CHUNK];
        end
      end
    end
  end

  assign out_valid = g_stage[c_STAGES-1].r_valid;
  assign result    = {g_stage[c_STAGES-1].r_carry, g_stage[c_STAGES-1].r_sum};
  assign ovf       = g_stage[c_STAGES-1].g_last.r_ovf;

endmodule
`default_nettype wire
